// File: rtl/l2_port_arbiter.sv
// rtl/l2_port_arbiter.sv - three-way arbiter sharing the 256-bit L2 line port
//
// Purpose:
//   Multiplexes the dcache miss path, the icache miss path and the next-line
//   instruction prefetcher onto a single L2 request port. Fixed priority is
//   dcache > icache > prefetch. The priority can be overridden so that an
//   icache miss is not starved by a stream of dcache traffic. An icache miss
//   to the line a granted prefetch is already fetching is answered from that
//   prefetch instead of being issued to L2 a second time.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   dcache_read/write         dcache line read / writeback (write wins if both)
//   dcache_address/wdata      dcache line address, writeback data
//   dcache_rdata/resp         returned line, one-cycle completion pulse
//   icache_read/address       icache line read request and address
//   icache_rdata/resp         returned line, one-cycle completion pulse
//   pf_read/address           prefetcher line read request and address
//   pf_rdata/resp             returned line, one-cycle completion pulse
//   l2_read/write             L2 request, held until l2_resp
//   l2_address/wdata          registered line address (bits [4:0] = 0) and data
//   l2_rdata/resp             L2 read data and one-cycle completion

module l2_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic         clk,
  input  logic         rst,

  input  logic         dcache_read,
  input  logic         dcache_write,
  input  logic [31:0]  dcache_address,
  input  logic [255:0] dcache_wdata,
  output logic [255:0] dcache_rdata,
  output logic         dcache_resp,

  input  logic         icache_read,
  input  logic [31:0]  icache_address,
  output logic [255:0] icache_rdata,
  output logic         icache_resp,

  input  logic         pf_read,
  input  logic [31:0]  pf_address,
  output logic [255:0] pf_rdata,
  output logic         pf_resp,

  output logic         l2_read,
  output logic         l2_write,
  output logic [31:0]  l2_address,
  output logic [255:0] l2_wdata,
  input  logic [255:0] l2_rdata,
  input  logic         l2_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_D = 2'd1,
    SERVE_I = 2'd2,
    SERVE_P = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   starve_cnt_q, starve_cnt_d;
  logic [31:0]        l2_address_q, l2_address_d;
  logic [255:0]       l2_wdata_q, l2_wdata_d;
  logic               op_write_q, op_write_d;

  logic               dcache_req;
  logic               icache_starved;
  logic               pf_merge;

  // Only line-granular address bits matter; the byte offset is discarded.
  logic               unused_offset_bits;
  assign unused_offset_bits = ^{dcache_address[4:0], icache_address[4:0], pf_address[4:0]};

  assign dcache_req     = dcache_read | dcache_write;
  assign icache_starved = icache_read && (starve_cnt_q == STARVE_MAX);

  // An icache miss that hits the line a granted prefetch is fetching rides on
  // that prefetch's response rather than becoming a second L2 read.
  assign pf_merge = (state_q == SERVE_P) && icache_read &&
                    (icache_address[31:5] == l2_address_q[31:5]);

  // Next-state, grant latching and starvation bookkeeping.
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    l2_address_d = l2_address_q;
    l2_wdata_d   = l2_wdata_q;
    op_write_d   = op_write_q;

    case (state_q)
      IDLE: begin
        if (icache_starved) begin
          state_d      = SERVE_I;
          l2_address_d = {icache_address[31:5], 5'b0};
          op_write_d   = 1'b0;
          starve_cnt_d = '0;
        end else if (dcache_req) begin
          state_d      = SERVE_D;
          l2_address_d = {dcache_address[31:5], 5'b0};
          // A simultaneous read and write is treated as a writeback.
          op_write_d   = dcache_write;
          if (dcache_write) begin
            l2_wdata_d = dcache_wdata;
          end
          if (icache_read && (starve_cnt_q != STARVE_MAX)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
          end
        end else if (icache_read) begin
          state_d      = SERVE_I;
          l2_address_d = {icache_address[31:5], 5'b0};
          op_write_d   = 1'b0;
          starve_cnt_d = '0;
        end else if (pf_read) begin
          state_d      = SERVE_P;
          l2_address_d = {pf_address[31:5], 5'b0};
          op_write_d   = 1'b0;
        end
      end

      SERVE_D, SERVE_I: begin
        if (l2_resp) begin
          state_d = IDLE;
        end
      end

      SERVE_P: begin
        // A prefetch is never aborted; a non-matching icache miss waits.
        if (l2_resp) begin
          state_d = IDLE;
          if (pf_merge) begin
            starve_cnt_d = '0;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Completion pulses go straight from l2_resp to the owner(s) so the
  // requester sees data in the same cycle L2 delivers it.
  always_comb begin
    dcache_resp = 1'b0;
    icache_resp = 1'b0;
    pf_resp     = 1'b0;
    if (l2_resp) begin
      case (state_q)
        SERVE_D: dcache_resp = 1'b1;
        SERVE_I: icache_resp = 1'b1;
        SERVE_P: begin
          pf_resp     = 1'b1;
          icache_resp = pf_merge;
        end
        default: begin
          dcache_resp = 1'b0;
        end
      endcase
    end
  end

  // Read data is broadcast; only the owner's resp qualifies it.
  assign dcache_rdata = l2_rdata;
  assign icache_rdata = l2_rdata;
  assign pf_rdata     = l2_rdata;

  assign l2_read    = (state_q != IDLE) && !op_write_q;
  assign l2_write   = (state_q != IDLE) &&  op_write_q;
  assign l2_address = l2_address_q;
  assign l2_wdata   = l2_wdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      l2_address_q <= '0;
      l2_wdata_q   <= '0;
      op_write_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      l2_address_q <= l2_address_d;
      l2_wdata_q   <= l2_wdata_d;
      op_write_q   <= op_write_d;
    end
  end

endmodule

// File: tb/tb_l2_port_arbiter.sv
// tb/tb_l2_port_arbiter.sv - cycle-table and sequence bench for l2_port_arbiter

module tb_l2_port_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         dcache_read, dcache_write;
  logic [31:0]  dcache_address;
  logic [255:0] dcache_wdata, dcache_rdata;
  logic         dcache_resp;
  logic         icache_read;
  logic [31:0]  icache_address;
  logic [255:0] icache_rdata;
  logic         icache_resp;
  logic         pf_read;
  logic [31:0]  pf_address;
  logic [255:0] pf_rdata;
  logic         pf_resp;
  logic         l2_read, l2_write;
  logic [31:0]  l2_address;
  logic [255:0] l2_wdata, l2_rdata;
  logic         l2_resp;

  l2_port_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .dcache_read(dcache_read), .dcache_write(dcache_write),
    .dcache_address(dcache_address), .dcache_wdata(dcache_wdata),
    .dcache_rdata(dcache_rdata), .dcache_resp(dcache_resp),
    .icache_read(icache_read), .icache_address(icache_address),
    .icache_rdata(icache_rdata), .icache_resp(icache_resp),
    .pf_read(pf_read), .pf_address(pf_address),
    .pf_rdata(pf_rdata), .pf_resp(pf_resp),
    .l2_read(l2_read), .l2_write(l2_write),
    .l2_address(l2_address), .l2_wdata(l2_wdata),
    .l2_rdata(l2_rdata), .l2_resp(l2_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rst, dr, dw;
    logic [31:0]  da;
    logic [255:0] dwd;
    logic         ir;
    logic [31:0]  ia;
    logic         pr;
    logic [31:0]  pa;
    logic         lr;
    logic [255:0] lrd;
    logic         e_rd, e_wr;
    logic [31:0]  e_addr;
    logic [255:0] e_wd;
    logic         e_dresp, e_iresp, e_presp;
  } vec_t;

  vec_t vecs[$];
  int total = 0;
  int bad = 0;

  localparam logic [255:0] Z  = '0;
  localparam logic [255:0] A5 = {32{8'hA5}};
  localparam logic [255:0] W1 = {8{32'hDEAD_BEEF}};
  localparam logic [255:0] R1 = {8{32'h0101_0101}};
  localparam logic [255:0] R2 = {8{32'h1111_2222}};
  localparam logic [255:0] R3 = {8{32'h3333_4444}};
  localparam logic [255:0] R4 = {8{32'h5555_6666}};
  localparam logic [255:0] R5 = {8{32'h7777_8888}};
  localparam logic [255:0] R6 = {8{32'h9999_AAAA}};

  task automatic add(input logic rs, input logic dr, input logic dw, input logic [31:0] da,
                     input logic [255:0] dwd, input logic ir, input logic [31:0] ia,
                     input logic pr, input logic [31:0] pa, input logic lr, input logic [255:0] lrd,
                     input logic erd, input logic ewr, input logic [31:0] eaddr, input logic [255:0] ewd,
                     input logic edr, input logic eir, input logic epr);
    vec_t v;
    v.rst = rs; v.dr = dr; v.dw = dw; v.da = da; v.dwd = dwd; v.ir = ir; v.ia = ia;
    v.pr = pr; v.pa = pa; v.lr = lr; v.lrd = lrd;
    v.e_rd = erd; v.e_wr = ewr; v.e_addr = eaddr; v.e_wd = ewd;
    v.e_dresp = edr; v.e_iresp = eir; v.e_presp = epr;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic exp_i [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    rst = 1'b1;
    dcache_read = 0; dcache_write = 0; dcache_address = 0; dcache_wdata = 0;
    icache_read = 0; icache_address = 0; pf_read = 0; pf_address = 0;
    l2_resp = 0; l2_rdata = 0;

    // Dcache read of 0x1234 with a late L2 response.
    add(0,0,0,0,Z,0,0,0,0,0,Z, 0,0,0,Z, 0,0,0);
    add(0,1,0,'h1234,Z,0,0,0,0,0,Z, 0,0,0,Z, 0,0,0);
    for (int k = 0; k < 4; k++) add(0,1,0,'h1234,Z,0,0,0,0,0,Z, 1,0,'h1220,Z, 0,0,0);
    add(0,1,0,'h1234,Z,0,0,0,0,1,A5, 1,0,'h1220,Z, 1,0,0);
    add(0,0,0,0,Z,0,0,0,0,0,Z, 0,0,'h1220,Z, 0,0,0);
    // Dcache write and icache read together: write first, icache after an idle cycle.
    add(0,0,1,'h2040,W1,1,'h3000,0,0,0,Z, 0,0,'h1220,Z, 0,0,0);
    add(0,0,1,'h2040,W1,1,'h3000,0,0,0,Z, 0,1,'h2040,W1, 0,0,0);
    add(0,0,1,'h2040,W1,1,'h3000,0,0,1,R1, 0,1,'h2040,W1, 1,0,0);
    add(0,0,0,0,Z,1,'h3000,0,0,0,Z, 0,0,'h2040,W1, 0,0,0);
    add(0,0,0,0,Z,1,'h3000,0,0,0,Z, 1,0,'h3000,W1, 0,0,0);
    add(0,0,0,0,Z,1,'h3000,0,0,1,R2, 1,0,'h3000,W1, 0,1,0);
    add(0,0,0,0,Z,0,0,0,0,0,Z, 0,0,'h3000,W1, 0,0,0);
    // Stray l2_resp while idle.
    add(0,0,0,0,Z,0,0,0,0,1,R2, 0,0,'h3000,W1, 0,0,0);
    // Prefetch 0x400 merged with icache miss to 0x41C.
    add(0,0,0,0,Z,0,0,1,'h400,0,Z, 0,0,'h3000,W1, 0,0,0);
    add(0,0,0,0,Z,0,0,1,'h400,0,Z, 1,0,'h400,W1, 0,0,0);
    add(0,0,0,0,Z,1,'h41C,1,'h400,0,Z, 1,0,'h400,W1, 0,0,0);
    add(0,0,0,0,Z,1,'h41C,1,'h400,1,R3, 1,0,'h400,W1, 0,1,1);
    add(0,0,0,0,Z,0,0,0,0,0,Z, 0,0,'h400,W1, 0,0,0);
    add(0,0,0,0,Z,0,0,0,0,0,Z, 0,0,'h400,W1, 0,0,0);
    // Prefetch 0x400 with icache miss to a different line 0x800.
    add(0,0,0,0,Z,0,0,1,'h400,0,Z, 0,0,'h400,W1, 0,0,0);
    add(0,0,0,0,Z,1,'h800,1,'h400,0,Z, 1,0,'h400,W1, 0,0,0);
    add(0,0,0,0,Z,1,'h800,1,'h400,1,R4, 1,0,'h400,W1, 0,0,1);
    add(0,0,0,0,Z,1,'h800,0,0,0,Z, 0,0,'h400,W1, 0,0,0);
    add(0,0,0,0,Z,1,'h800,0,0,0,Z, 1,0,'h800,W1, 0,0,0);
    add(0,0,0,0,Z,1,'h800,0,0,1,R5, 1,0,'h800,W1, 0,1,0);
    add(0,0,0,0,Z,0,0,0,0,0,Z, 0,0,'h800,W1, 0,0,0);
    // Reset two cycles into a dcache read, stale response, re-issue.
    add(0,1,0,'h5000,Z,0,0,0,0,0,Z, 0,0,'h800,W1, 0,0,0);
    add(0,1,0,'h5000,Z,0,0,0,0,0,Z, 1,0,'h5000,W1, 0,0,0);
    add(1,1,0,'h5000,Z,0,0,0,0,0,Z, 1,0,'h5000,W1, 0,0,0);
    add(0,0,0,0,Z,0,0,0,0,0,Z, 0,0,0,Z, 0,0,0);
    add(0,0,0,0,Z,0,0,0,0,1,R6, 0,0,0,Z, 0,0,0);
    add(0,1,0,'h5000,Z,0,0,0,0,0,Z, 0,0,0,Z, 0,0,0);
    add(0,1,0,'h5000,Z,0,0,0,0,0,Z, 1,0,'h5000,Z, 0,0,0);
    add(0,1,0,'h5000,Z,0,0,0,0,1,R6, 1,0,'h5000,Z, 1,0,0);
    add(0,0,0,0,Z,0,0,0,0,0,Z, 0,0,'h5000,Z, 0,0,0);

    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      @(posedge clk); #1;
      rst = vecs[i].rst;
      dcache_read = vecs[i].dr; dcache_write = vecs[i].dw;
      dcache_address = vecs[i].da; dcache_wdata = vecs[i].dwd;
      icache_read = vecs[i].ir; icache_address = vecs[i].ia;
      pf_read = vecs[i].pr; pf_address = vecs[i].pa;
      l2_resp = vecs[i].lr; l2_rdata = vecs[i].lrd;
      @(negedge clk);
      chk($sformatf("v%0d l2_read", i), 256'(l2_read), 256'(vecs[i].e_rd));
      chk($sformatf("v%0d l2_write", i), 256'(l2_write), 256'(vecs[i].e_wr));
      chk($sformatf("v%0d l2_address", i), 256'(l2_address), 256'(vecs[i].e_addr));
      chk($sformatf("v%0d l2_wdata", i), l2_wdata, vecs[i].e_wd);
      chk($sformatf("v%0d dcache_resp", i), 256'(dcache_resp), 256'(vecs[i].e_dresp));
      chk($sformatf("v%0d icache_resp", i), 256'(icache_resp), 256'(vecs[i].e_iresp));
      chk($sformatf("v%0d pf_resp", i), 256'(pf_resp), 256'(vecs[i].e_presp));
      if (vecs[i].e_dresp && vecs[i].e_rd) chk($sformatf("v%0d dcache_rdata", i), dcache_rdata, vecs[i].lrd);
      if (vecs[i].e_iresp) chk($sformatf("v%0d icache_rdata", i), icache_rdata, vecs[i].lrd);
      if (vecs[i].e_presp) chk($sformatf("v%0d pf_rdata", i), pf_rdata, vecs[i].lrd);
    end

    // Starvation: icache held while dcache keeps a request pending.
    begin
      int k;
      bit timed_out;
      logic owner_i;
      k = 0;
      timed_out = 0;
      @(posedge clk); #1;
      dcache_read = 1; dcache_address = 32'h7000;
      icache_read = 1; icache_address = 32'h6000;
      for (int g = 0; g < 6 && !timed_out; g++) begin
        int cyc;
        cyc = 0;
        @(negedge clk);
        while (!l2_read && cyc < 20) begin
          @(negedge clk);
          cyc++;
        end
        if (!l2_read) begin
          chk($sformatf("stv grant %0d timeout", g), 256'(l2_read), 256'(1));
          timed_out = 1;
        end else begin
          owner_i = (l2_address == 32'h6000);
          chk($sformatf("stv grant %0d is_icache", g), 256'(owner_i), 256'(exp_i[g]));
          if (owner_i) chk("stv starve_cnt after I grant", 256'(dut.starve_cnt_q), 256'(0));
          @(posedge clk); #1;
          l2_resp = 1; l2_rdata = {8{32'(g)}};
          @(negedge clk);
          if (owner_i) chk($sformatf("stv icache_resp %0d", g), 256'(icache_resp), 256'(1));
          else chk($sformatf("stv dcache_resp %0d", g), 256'(dcache_resp), 256'(1));
          @(posedge clk); #1;
          l2_resp = 0;
          if (owner_i) icache_read = 0;
          else begin
            k++;
            if (k < 5) dcache_address = 32'h7000 + 32'(k) * 32'd32;
            else dcache_read = 0;
          end
        end
      end
      dcache_read = 0; icache_read = 0;
      @(negedge clk);
      chk("stv final idle l2_read", 256'(l2_read), 256'(0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
